kbd_matrix_sync: RTL
====================

# kbd_matrix_sync

Synchronous, parametrised keyboard-matrix interceptor between the CPU bus and PIA1. The RPi writes a cached key matrix through a bus window at MATRIX_BASE. The CPU selects a row by writing PIA port A. CPU reads of PIA port B are then served from the cache whenever the selected row has a key down. Compared with the earlier strobe-clocked version, this block:

- runs on one clock with edge-detected strobes;
- has configurable row count and column width;
- returns a safe value for out-of-range rows;
- adds a staleness watchdog that releases all keys if the RPi stops refreshing.

## Interface

Parameters:
- ROWS, 10, number of matrix rows (1..16)
- COLS, 8, column width / data_out width (1..8)
- MATRIX_BASE, 17'hE800, first RPi write address; rows occupy MATRIX_BASE..MATRIX_BASE+ROWS-1
- PORT_A_ADDR, 17'hE810, CPU row-select address
- PORT_B_ADDR, 17'hE812, CPU column-read address
- TIMEOUT, 24'd1_600_000, clk cycles without an RPi matrix write before the cache is released
- TIMEOUT_W, 24, watchdog counter width

Ports:
- clk  in  1  system clock; all state changes on rising edge
- res_b  in  1  asynchronous, active-low reset
- addr  in  17  bus address
- data_in  in  8  bus write data
- data_out  out  COLS  cached column bits of selected row (1 = released)
- cpu_select  in  1  CPU cycle in progress
- cpu_write_strobe  in  1  CPU write strobe, level, synchronous to clk
- pi_write_strobe  in  1  RPi write strobe, level, synchronous to clk
- oe  out  1  1 = PIA drives bus; 0 = this block drives data_out
- stale  out  1  1 = cache released by reset or watchdog; no RPi write since

## Operation

- Strobe edge detection:
  - Each strobe is registered (cws_q, pws_q; reset value 0).
  - A write commits in the cycle where strobe_q=1 and strobe=0 (falling edge).
  - addr and data_in are sampled in that cycle.
- Row select:
  - On a CPU falling edge with addr==PORT_A_ADDR, sel_row <= data_in[3:0].
  - sel_row is always stored, even if ≥ROWS.
- Matrix write:
  - On an RPi falling edge with MATRIX_BASE ≤ addr < MATRIX_BASE+ROWS, row[addr-MATRIX_BASE] <= data_in[COLS-1:0].
  - Writes outside the window are ignored.
- data_out:
  - row[sel_row] if sel_row < ROWS, else all ones.
  - Combinational from registered state.
- oe = !(cpu_select && addr==PORT_B_ADDR && data_out != all-ones). Combinational.
- Watchdog:
  - Counter wd reloads to 0 on every valid matrix write.
  - Otherwise wd increments, saturating at TIMEOUT.
  - When wd reaches TIMEOUT-1 and no valid matrix write occurs that cycle: all rows <= all ones, stale <= 1, wd <= TIMEOUT (held).
  - Any valid matrix write clears stale (stale <= 0) in its commit cycle.
- Reset (res_b=0, asynchronous):
  - all rows all-ones; sel_row=0; wd=0; stale=1; cws_q=pws_q=0.
  - Hence data_out=all-ones and oe=1.

## Timing

- Write latency: a strobe falls in cycle N (first clk edge sampling it low). State updates at the end of cycle N. data_out and oe reflect the new state in cycle N+1.
- addr and data_in must be stable during the sampling cycle N. A strobe held low for multiple cycles commits once.
- Strobe high-to-low-to-high within one clk period is not detected (minimum strobe width: one cycle high, one cycle low).
- Simultaneous CPU and RPi falling edges: both commit in the same cycle. data_out in N+1 uses the new sel_row and the new row contents.
- Watchdog expiry and a matrix write in the same cycle: the write wins and expiry is suppressed. wd=0, stale=0, and the written row holds the new data; no rows are cleared.
- After expiry, wd stays at TIMEOUT until the next matrix write; no repeated clears are needed.
- Reset asserted mid-operation: all state returns to reset values immediately. Edge detectors restart at 0, so a strobe already low at deassertion does not commit.

## Test plan

- Reset: hold res_b=0, then release. Expect data_out=8'hFF, oe=1, stale=1. Then a CPU read at 17'hE812 → oe=1.
- Basic intercept: RPi writes 8'hFE to 17'hE803; CPU writes 8'h03 to 17'hE810; CPU reads 17'hE812. Expect data_out=8'hFE and oe=0 one cycle after the last strobe falls. Also expect stale=0.
- Out of range:
  - CPU selects row 8'h0C → data_out=8'hFF, oe=1.
  - RPi write to 17'hE80A → no row changes.
  - Repeat with ROWS=16 → row 12 is addressable.
- Multi-cycle strobe: hold pi_write_strobe low 5 cycles while data_in changes from 8'h7F to 8'h00 after cycle 1. Expect the row = 8'h7F (single commit).
- Watchdog (TIMEOUT=16):
  - Write row 0 = 8'h00, select row 0; after 16 idle cycles, data_out=8'hFF and stale=1.
  - Separately, issue a write on the exact expiry cycle → expect no clear and stale=0.
- Reset mid-operation: assert res_b while pi_write_strobe is low with row 2 = 8'h00. Expect immediate data_out=8'hFF and all rows 8'hFF. A strobe still low at release does not commit.

Source files
------------

// File: rtl/kbd_matrix_sync_if.sv
// Bus-side signal bundle for kbd_matrix_sync: shared CPU/RPi address and data,
// the two write strobes, and the intercepted column data with its drive enable.
interface kbd_matrix_sync_if #(
    parameter int COLS = 8
);
    logic [16:0]     addr;
    logic [7:0]      data_in;
    logic [COLS-1:0] data_out;
    logic            cpu_select;
    logic            cpu_write_strobe;
    logic            pi_write_strobe;
    logic            oe;
    logic            stale;

    modport master (
        output addr, data_in, cpu_select, cpu_write_strobe, pi_write_strobe,
        input  data_out, oe, stale
    );

    modport slave (
        input  addr, data_in, cpu_select, cpu_write_strobe, pi_write_strobe,
        output data_out, oe, stale
    );
endinterface

// File: rtl/kbd_matrix_sync.sv
// Keyboard-matrix interceptor: RPi-written row cache served on CPU port-B reads, with staleness watchdog.
// Writes commit on the strobe falling edge, visible one cycle later; no backpressure (bus is never stalled).
module kbd_matrix_sync #(
    parameter int          ROWS        = 10,
    parameter int          COLS        = 8,
    parameter logic [16:0] MATRIX_BASE = 17'hE800,
    parameter logic [16:0] PORT_A_ADDR = 17'hE810,
    parameter logic [16:0] PORT_B_ADDR = 17'hE812,
    parameter int          TIMEOUT_W   = 24,
    parameter logic [TIMEOUT_W-1:0] TIMEOUT = TIMEOUT_W'(1_600_000)
) (
    input  logic             clk,
    input  logic             res_b,
    kbd_matrix_sync_if.slave bus
);
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_M1 = TIMEOUT - 1'b1;

    logic                 cws_q, pws_q;
    logic [3:0]           sel_row_q, sel_row_d;
    logic [COLS-1:0]      rows_q [ROWS];
    logic [COLS-1:0]      rows_d [ROWS];
    logic [TIMEOUT_W-1:0] wd_q, wd_d;
    logic                 stale_q, stale_d;

    logic                 cpu_commit, pi_commit, pi_valid;
    logic [17:0]          addr_off;
    logic [3:0]           pi_idx;
    logic                 row_in_range;
    logic [COLS-1:0]      dout;

    assign cpu_commit = cws_q & ~bus.cpu_write_strobe;
    assign pi_commit  = pws_q & ~bus.pi_write_strobe;

    // 18-bit offset keeps the window test free of wraparound near the top of the map
    assign addr_off = {1'b0, bus.addr} - {1'b0, MATRIX_BASE};
    assign pi_idx   = addr_off[3:0];
    assign pi_valid = pi_commit && (bus.addr >= MATRIX_BASE) && (addr_off < 18'(ROWS));

    always_comb begin
        sel_row_d = sel_row_q;
        rows_d    = rows_q;
        wd_d      = wd_q;
        stale_d   = stale_q;

        if (cpu_commit && bus.addr == PORT_A_ADDR) begin
            sel_row_d = bus.data_in[3:0];
        end

        // A write landing on the expiry cycle takes priority, so no rows are released
        if (pi_valid) begin
            rows_d[pi_idx] = bus.data_in[COLS-1:0];
            wd_d           = '0;
            stale_d        = 1'b0;
        end else if (wd_q == TIMEOUT_M1) begin
            for (int r = 0; r < ROWS; r++) begin
                rows_d[r] = '1;
            end
            stale_d = 1'b1;
            wd_d    = TIMEOUT;
        end else if (wd_q != TIMEOUT) begin
            wd_d = wd_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge res_b) begin
        if (!res_b) begin
            cws_q     <= 1'b0;
            pws_q     <= 1'b0;
            sel_row_q <= '0;
            wd_q      <= '0;
            stale_q   <= 1'b1;
            for (int r = 0; r < ROWS; r++) begin
                rows_q[r] <= '1;
            end
        end else begin
            cws_q     <= bus.cpu_write_strobe;
            pws_q     <= bus.pi_write_strobe;
            sel_row_q <= sel_row_d;
            wd_q      <= wd_d;
            stale_q   <= stale_d;
            for (int r = 0; r < ROWS; r++) begin
                rows_q[r] <= rows_d[r];
            end
        end
    end

    // Row selects beyond the matrix read as "no key down"
    assign row_in_range = {1'b0, sel_row_q} < 5'(ROWS);
    assign dout         = row_in_range ? rows_q[sel_row_q] : '1;

    assign bus.data_out = dout;
    assign bus.oe       = !(bus.cpu_select && bus.addr == PORT_B_ADDR && dout != '1);
    assign bus.stale    = stale_q;
endmodule
